idecode_fwd: RTL and testbench
==============================

// Module: idecode_fwd
// PURPOSE
//  Parametrised decode stage for the bexkat1 pipeline: decodes ir_i, reads two operands from an internal
//  register file, forwards EX and WB results per half-word lane, detects load-use hazards, and registers
//  the result to EX behind a valid/stall/flush handshake. Sits between fetch and execute; 1-cycle latency.
// PARAMETERS
//  DATA_W  32  register/operand width; must be even (two write lanes of DATA_W/2)
//  NREGS   16  register count; AW = $clog2(NREGS) address bits
//  IR_W    64  instruction word width; decode fields are ir_i[31:12]
//  FWD_EN  1   1: EX/WB forwarding enabled; 0: regfile data only, any RAW on EX dest stalls
// PORTS
//  clk_i          in   1       clock
//  rst_i          in   1       synchronous active-high reset
//  valid_i        in   1       ir_i/pc_i hold a valid instruction
//  ir_i           in   IR_W    instruction
//  pc_i           in   32      instruction PC
//  stall_i        in   1       EX cannot accept; hold outputs
//  flush_i        in   1       kill instruction in this stage
//  wb_write_i     in   2       WB lane write enable {hi,lo}
//  wb_addr_i      in   AW      WB destination
//  wb_data_i      in   DATA_W  WB data
//  ex_write_i     in   2       EX-stage lane write enable
//  ex_addr_i      in   AW      EX destination
//  ex_data_i      in   DATA_W  EX result (ignored when ex_is_load_i)
//  ex_is_load_i   in   1       EX instruction is T_LOAD (data not yet available)
//  ready_o        out  1       stage accepts ir_i this cycle (combinational)
//  hazard_o       out  1       load-use hazard this cycle (combinational)
//  valid_o        out  1       registered outputs hold a valid instruction
//  ir_o           out  IR_W    registered instruction
//  pc_o           out  32      registered PC
//  reg_write_o    out  2       registered lane write enable for this instruction
//  reg_data_out1  out  DATA_W  operand 1
//  reg_data_out2  out  DATA_W  operand 2
// BEHAVIOUR
//  - Reset (rst_i sampled high at clk edge): valid_o, ir_o, pc_o, reg_write_o, reg_data_out1/2 <= 0;
//    all NREGS registers <= 0. Reset wins over every other input.
//  - Fields: type=ir_i[31:28], op=[27:24], ra=[23:20], rb=[19:16], rc=[15:12], truncated/zero-ext to AW.
//  - Sources: T_CMP/T_STORE/T_LOAD read1=ra, read2=rb; all other types read1=rb, read2=rc.
//    Used: T_LDI none; T_MOV read1 only; all others both.
//  - reg_write_next: T_LDI/T_LOAD/T_ALU 2'b11; T_MOV op[1:0]; else 2'b00.
//  - Regfile: on clk edge, lane L of reg[wb_addr_i] <= wb_data_i lane L when wb_write_i[L].
//  - Operand mux per lane L (lo=[DATA_W/2-1:0], hi=upper): EX if ex_write_i[L] && addr match && !ex_is_load_i
//    && FWD_EN; else WB if wb_write_i[L] && addr match (same-cycle write-through, always on); else regfile.
//  - hazard_o = valid_i && used source matches ex_addr_i && |ex_write_i && (ex_is_load_i || !FWD_EN).
//  - ready_o = !stall_i && !hazard_o.
//  - Clock edge, priority: rst_i > flush_i > stall_i > hazard > advance.
//    flush_i: valid_o<=0, reg_write_o<=0 (others don't-care, hold); overrides stall_i.
//    stall_i: all outputs hold; operands are NOT re-sampled (EX owns forwarding while stalled).
//    hazard (no stall): bubble, valid_o<=0, reg_write_o<=0; fetch holds ir_i, retried next cycle.
//    advance: valid_o<=valid_i; ir_o/pc_o/operands <= next; reg_write_o<=valid_i ? reg_write_next : 0.
//  - No internal FSM beyond the output register; a hazard lasts exactly while EX holds the load.
// TESTING
//  1 rst_i high 1 cycle mid-stream -> next cycle all outputs 0, regfile 0, valid_o=0.
//  2 WB writes r3=0x1234_5678 lanes 11 same cycle T_ALU reads rb=3 -> reg_data_out1=0x12345678 next cycle.
//  3 EX r5=0xAAAA_BBBB lanes 01, regfile r5=0x1111_2222, T_ALU rc=5 -> reg_data_out2=0x1111_BBBB.
//  4 EX T_LOAD dest r2, decode T_ALU rb=2 -> hazard_o=1, ready_o=0, valid_o=0 next; EX clears -> issues.
//  5 stall_i 3 cycles with valid out -> outputs unchanged; flush_i during stall -> valid_o=0, reg_write_o=0.
//  6 T_MOV op=4'b0010 -> reg_write_o=2'b10; T_CMP -> 2'b00; FWD_EN=0 + EX match -> hazard_o=1.

Source files
------------

// File: rtl/idecode_fwd.sv
// rtl/idecode_fwd.sv - bexkat1 decode stage with register file, per-lane forwarding and load-use hazard detection
//
// Purpose: decodes the instruction word, reads two operands from an internal
// register file with EX/WB forwarding per half-word lane, detects load-use
// hazards and registers the decoded instruction towards EX behind a
// valid/stall/flush handshake (1-cycle latency).
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   valid_i, ir_i, pc_i          incoming instruction from fetch
//   stall_i, flush_i             EX back-pressure, kill of this stage
//   wb_write_i/addr_i/data_i     write-back port (per-lane write enable {hi,lo})
//   ex_write_i/addr_i/data_i     EX-stage result for forwarding
//   ex_is_load_i                 EX result is a load, data not yet available
//   ready_o, hazard_o            combinational accept / load-use hazard
//   valid_o, ir_o, pc_o          registered instruction towards EX
//   reg_write_o                  registered lane write enable
//   reg_data_out1/2              registered operands
module idecode_fwd #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16,
  parameter int IR_W   = 64,
  parameter int FWD_EN = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     valid_i,
  input  logic [IR_W-1:0]          ir_i,
  input  logic [31:0]              pc_i,
  input  logic                     stall_i,
  input  logic                     flush_i,
  input  logic [1:0]               wb_write_i,
  input  logic [$clog2(NREGS)-1:0] wb_addr_i,
  input  logic [DATA_W-1:0]        wb_data_i,
  input  logic [1:0]               ex_write_i,
  input  logic [$clog2(NREGS)-1:0] ex_addr_i,
  input  logic [DATA_W-1:0]        ex_data_i,
  input  logic                     ex_is_load_i,
  output logic                     ready_o,
  output logic                     hazard_o,
  output logic                     valid_o,
  output logic [IR_W-1:0]          ir_o,
  output logic [31:0]              pc_o,
  output logic [1:0]               reg_write_o,
  output logic [DATA_W-1:0]        reg_data_out1,
  output logic [DATA_W-1:0]        reg_data_out2
);

  localparam int AW = $clog2(NREGS);
  localparam int HW = DATA_W / 2;
  localparam bit FWD = (FWD_EN != 0);

  localparam logic [3:0] T_CMP   = 4'h3;
  localparam logic [3:0] T_MOV   = 4'h4;
  localparam logic [3:0] T_ALU   = 4'h6;
  localparam logic [3:0] T_LDI   = 4'ha;
  localparam logic [3:0] T_LOAD  = 4'hb;
  localparam logic [3:0] T_STORE = 4'hc;

  logic [DATA_W-1:0] r_regs [NREGS];

  logic              r_valid;
  logic [IR_W-1:0]   r_ir;
  logic [31:0]       r_pc;
  logic [1:0]        r_reg_write;
  logic [DATA_W-1:0] r_data1;
  logic [DATA_W-1:0] r_data2;

  logic [3:0]        w_type;
  logic [3:0]        w_op;
  logic [AW-1:0]     w_ra;
  logic [AW-1:0]     w_rb;
  logic [AW-1:0]     w_rc;
  logic [AW-1:0]     w_src1;
  logic [AW-1:0]     w_src2;
  logic              w_use1;
  logic              w_use2;
  logic [1:0]        w_reg_write_next;
  logic [DATA_W-1:0] w_op1;
  logic [DATA_W-1:0] w_op2;
  logic              w_ex_match;
  logic              w_hazard;

  assign w_type = ir_i[31:28];
  assign w_op   = ir_i[27:24];
  assign w_ra   = AW'(ir_i[23:20]);
  assign w_rb   = AW'(ir_i[19:16]);
  assign w_rc   = AW'(ir_i[15:12]);

  always_comb begin
    w_src1           = w_rb;
    w_src2           = w_rc;
    w_use1           = 1'b1;
    w_use2           = 1'b1;
    w_reg_write_next = 2'b00;
    case (w_type)
      T_CMP, T_STORE: begin
        w_src1 = w_ra;
        w_src2 = w_rb;
      end
      T_LOAD: begin
        w_src1           = w_ra;
        w_src2           = w_rb;
        w_reg_write_next = 2'b11;
      end
      T_LDI: begin
        w_use1           = 1'b0;
        w_use2           = 1'b0;
        w_reg_write_next = 2'b11;
      end
      T_ALU: w_reg_write_next = 2'b11;
      T_MOV: begin
        w_use2           = 1'b0;
        w_reg_write_next = w_op[1:0];
      end
      default: ;
    endcase
  end

  // EX beats WB beats the array, independently per lane. A load in EX has no
  // data yet, so it never forwards; the hazard below holds the instruction.
  always_comb begin
    w_op1 = r_regs[w_src1];
    w_op2 = r_regs[w_src2];
    for (int l = 0; l < 2; l++) begin
      if (FWD && ex_write_i[l] && ex_addr_i == w_src1 && !ex_is_load_i)
        w_op1[l*HW +: HW] = ex_data_i[l*HW +: HW];
      else if (wb_write_i[l] && wb_addr_i == w_src1)
        w_op1[l*HW +: HW] = wb_data_i[l*HW +: HW];
      if (FWD && ex_write_i[l] && ex_addr_i == w_src2 && !ex_is_load_i)
        w_op2[l*HW +: HW] = ex_data_i[l*HW +: HW];
      else if (wb_write_i[l] && wb_addr_i == w_src2)
        w_op2[l*HW +: HW] = wb_data_i[l*HW +: HW];
    end
  end

  // Without forwarding every read of the EX destination has to wait.
  assign w_ex_match = (w_use1 && w_src1 == ex_addr_i) || (w_use2 && w_src2 == ex_addr_i);
  assign w_hazard   = valid_i && w_ex_match && (|ex_write_i) && (ex_is_load_i || !FWD);

  assign hazard_o = w_hazard;
  assign ready_o  = !stall_i && !w_hazard;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++)
        r_regs[i] <= '0;
    end else begin
      for (int l = 0; l < 2; l++)
        if (wb_write_i[l])
          r_regs[wb_addr_i][l*HW +: HW] <= wb_data_i[l*HW +: HW];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid     <= 1'b0;
      r_ir        <= '0;
      r_pc        <= '0;
      r_reg_write <= 2'b00;
      r_data1     <= '0;
      r_data2     <= '0;
    end else if (flush_i) begin
      r_valid     <= 1'b0;
      r_reg_write <= 2'b00;
    end else if (!stall_i) begin
      // While stalled nothing is re-sampled: EX owns forwarding into its
      // held operands until it accepts.
      if (w_hazard) begin
        r_valid     <= 1'b0;
        r_reg_write <= 2'b00;
      end else begin
        r_valid     <= valid_i;
        r_ir        <= ir_i;
        r_pc        <= pc_i;
        r_reg_write <= valid_i ? w_reg_write_next : 2'b00;
        r_data1     <= w_op1;
        r_data2     <= w_op2;
      end
    end
  end

  assign valid_o       = r_valid;
  assign ir_o          = r_ir;
  assign pc_o          = r_pc;
  assign reg_write_o   = r_reg_write;
  assign reg_data_out1 = r_data1;
  assign reg_data_out2 = r_data2;

endmodule

// File: tb/tb_idecode_fwd.sv
// tb/tb_idecode_fwd.sv - scoreboard bench for idecode_fwd with a behavioural reference model
module tb_idecode_fwd;

  localparam logic [3:0] T_CMP   = 4'h3;
  localparam logic [3:0] T_MOV   = 4'h4;
  localparam logic [3:0] T_ALU   = 4'h6;
  localparam logic [3:0] T_LDI   = 4'ha;
  localparam logic [3:0] T_LOAD  = 4'hb;
  localparam logic [3:0] T_STORE = 4'hc;

  typedef struct {
    logic        rst;
    logic        valid;
    logic [63:0] ir;
    logic [31:0] pc;
    logic        stall;
    logic        flush;
    logic [1:0]  wbw;
    logic [3:0]  wba;
    logic [31:0] wbd;
    logic [1:0]  exw;
    logic [3:0]  exa;
    logic [31:0] exd;
    logic        exl;
  } stim_t;

  typedef struct {
    logic hz;
    logic rdy;
    logic hznf;
  } exp_comb_t;

  typedef struct {
    logic        valid;
    logic [1:0]  rw;
    logic        chk;
    logic [63:0] ir;
    logic [31:0] pc;
    logic [31:0] d1;
    logic [31:0] d2;
  } exp_reg_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic [63:0] ir_i = '0;
  logic [31:0] pc_i = '0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [1:0]  wb_write_i = '0;
  logic [3:0]  wb_addr_i = '0;
  logic [31:0] wb_data_i = '0;
  logic [1:0]  ex_write_i = '0;
  logic [3:0]  ex_addr_i = '0;
  logic [31:0] ex_data_i = '0;
  logic        ex_is_load_i = 1'b0;

  logic        ready_o, hazard_o, valid_o;
  logic [63:0] ir_o;
  logic [31:0] pc_o;
  logic [1:0]  reg_write_o;
  logic [31:0] reg_data_out1, reg_data_out2;

  logic        nf_ready, nf_hazard, nf_valid;
  logic [63:0] nf_ir;
  logic [31:0] nf_pc;
  logic [1:0]  nf_rw;
  logic [31:0] nf_d1, nf_d2;

  always #5 clk = ~clk;

  idecode_fwd #(.DATA_W(32), .NREGS(16), .IR_W(64), .FWD_EN(1)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ir_i(ir_i), .pc_i(pc_i),
    .stall_i(stall_i), .flush_i(flush_i),
    .wb_write_i(wb_write_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .ex_write_i(ex_write_i), .ex_addr_i(ex_addr_i), .ex_data_i(ex_data_i),
    .ex_is_load_i(ex_is_load_i),
    .ready_o(ready_o), .hazard_o(hazard_o), .valid_o(valid_o), .ir_o(ir_o), .pc_o(pc_o),
    .reg_write_o(reg_write_o), .reg_data_out1(reg_data_out1), .reg_data_out2(reg_data_out2)
  );

  idecode_fwd #(.DATA_W(32), .NREGS(16), .IR_W(64), .FWD_EN(0)) u_dut_nf (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ir_i(ir_i), .pc_i(pc_i),
    .stall_i(stall_i), .flush_i(flush_i),
    .wb_write_i(wb_write_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .ex_write_i(ex_write_i), .ex_addr_i(ex_addr_i), .ex_data_i(ex_data_i),
    .ex_is_load_i(ex_is_load_i),
    .ready_o(nf_ready), .hazard_o(nf_hazard), .valid_o(nf_valid), .ir_o(nf_ir), .pc_o(nf_pc),
    .reg_write_o(nf_rw), .reg_data_out1(nf_d1), .reg_data_out2(nf_d2)
  );

  int tests = 0;
  int fails = 0;

  exp_comb_t comb_q[$];
  exp_reg_t  reg_q[$];

  logic [31:0] m_regs [16];
  exp_reg_t    m_out;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mk_ir(input logic [3:0] t, input logic [3:0] op,
                                        input logic [3:0] ra, input logic [3:0] rb,
                                        input logic [3:0] rc);
    logic [31:0] hi;
    logic [11:0] lo;
    hi = $urandom;
    lo = 12'($urandom);
    return {hi, t, op, ra, rb, rc, lo};
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s.rst = 0; s.valid = 0; s.ir = '0; s.pc = '0; s.stall = 0; s.flush = 0;
    s.wbw = 0; s.wba = 0; s.wbd = 0; s.exw = 0; s.exa = 0; s.exd = 0; s.exl = 0;
    return s;
  endfunction

  // Operand value from the register-file rules: each 16-bit half comes from
  // the freshest producer (EX result, then this cycle's write-back, then the array).
  function automatic logic [31:0] model_operand(input logic [3:0] a, input stim_t s);
    logic [31:0] v;
    logic [31:0] mask;
    v = m_regs[a];
    for (int l = 0; l < 2; l++) begin
      mask = (l == 0) ? 32'h0000_ffff : 32'hffff_0000;
      if (s.exw[l] && s.exa == a && !s.exl)
        v = (v & ~mask) | (s.exd & mask);
      else if (s.wbw[l] && s.wba == a)
        v = (v & ~mask) | (s.wbd & mask);
    end
    return v;
  endfunction

  task automatic cyc(input stim_t s);
    logic [3:0] t, a1, a2;
    logic       u1, u2, hz, hznf, depends;
    logic [1:0] rwn;
    exp_comb_t  ec;
    @(negedge clk);
    rst_i = s.rst; valid_i = s.valid; ir_i = s.ir; pc_i = s.pc;
    stall_i = s.stall; flush_i = s.flush;
    wb_write_i = s.wbw; wb_addr_i = s.wba; wb_data_i = s.wbd;
    ex_write_i = s.exw; ex_addr_i = s.exa; ex_data_i = s.exd; ex_is_load_i = s.exl;

    t = s.ir[31:28];
    if (t == T_CMP || t == T_STORE || t == T_LOAD) begin
      a1 = s.ir[23:20]; a2 = s.ir[19:16];
    end else begin
      a1 = s.ir[19:16]; a2 = s.ir[15:12];
    end
    u1 = (t != T_LDI);
    u2 = (t != T_LDI) && (t != T_MOV);
    if (t == T_LDI || t == T_LOAD || t == T_ALU) rwn = 2'b11;
    else if (t == T_MOV) rwn = s.ir[25:24];
    else rwn = 2'b00;

    depends = s.valid && (s.exw != 0) && ((u1 && a1 == s.exa) || (u2 && a2 == s.exa));
    hz   = depends && s.exl;
    hznf = depends;
    ec.hz = hz; ec.rdy = !s.stall && !hz; ec.hznf = hznf;
    comb_q.push_back(ec);

    if (s.rst) begin
      m_out.valid = 0; m_out.rw = 0; m_out.chk = 1;
      m_out.ir = 0; m_out.pc = 0; m_out.d1 = 0; m_out.d2 = 0;
    end else if (s.flush || (!s.stall && hz)) begin
      m_out.valid = 0; m_out.rw = 0; m_out.chk = 0;
    end else if (!s.stall) begin
      m_out.valid = s.valid;
      m_out.rw    = s.valid ? rwn : 2'b00;
      m_out.chk   = s.valid;
      m_out.ir    = s.ir;
      m_out.pc    = s.pc;
      m_out.d1    = model_operand(a1, s);
      m_out.d2    = model_operand(a2, s);
    end
    reg_q.push_back(m_out);

    if (s.rst) begin
      for (int i = 0; i < 16; i++) m_regs[i] = 0;
    end else begin
      if (s.wbw[0]) m_regs[s.wba][15:0]  = s.wbd[15:0];
      if (s.wbw[1]) m_regs[s.wba][31:16] = s.wbd[31:16];
    end
  endtask

  initial begin : monitor
    exp_comb_t ec;
    exp_reg_t  er;
    forever begin
      @(negedge clk);
      #2;
      if (comb_q.size() > 0) begin
        ec = comb_q.pop_front();
        check("hazard_o", 64'(hazard_o), 64'(ec.hz));
        check("ready_o", 64'(ready_o), 64'(ec.rdy));
        check("hazard_o_nofwd", 64'(nf_hazard), 64'(ec.hznf));
      end
      @(posedge clk);
      #2;
      if (reg_q.size() > 0) begin
        er = reg_q.pop_front();
        check("valid_o", 64'(valid_o), 64'(er.valid));
        check("reg_write_o", 64'(reg_write_o), 64'(er.rw));
        if (er.chk) begin
          check("ir_o", ir_o, er.ir);
          check("pc_o", 64'(pc_o), 64'(er.pc));
          check("reg_data_out1", 64'(reg_data_out1), 64'(er.d1));
          check("reg_data_out2", 64'(reg_data_out2), 64'(er.d2));
        end
      end
    end
  end

  initial begin : driver
    stim_t s;
    for (int i = 0; i < 16; i++) m_regs[i] = 0;
    m_out.valid = 0; m_out.rw = 0; m_out.chk = 0;
    m_out.ir = 0; m_out.pc = 0; m_out.d1 = 0; m_out.d2 = 0;

    s = idle(); s.rst = 1;
    cyc(s); cyc(s);

    // write-back write-through in the same cycle as the read
    s = idle(); s.valid = 1; s.pc = 32'h100; s.ir = mk_ir(T_ALU, 4'h0, 4'h0, 4'h3, 4'h0);
    s.wbw = 2'b11; s.wba = 4'h3; s.wbd = 32'h1234_5678;
    cyc(s);

    // EX forwards only its low lane, high lane comes from the array
    s = idle(); s.wbw = 2'b11; s.wba = 4'h5; s.wbd = 32'h1111_2222;
    cyc(s);
    s = idle(); s.valid = 1; s.pc = 32'h104; s.ir = mk_ir(T_ALU, 4'h0, 4'h1, 4'h0, 4'h5);
    s.exw = 2'b01; s.exa = 4'h5; s.exd = 32'haaaa_bbbb;
    cyc(s);

    // load-use: bubble while EX holds the load, then issue
    s = idle(); s.valid = 1; s.pc = 32'h108; s.ir = mk_ir(T_ALU, 4'h0, 4'h0, 4'h2, 4'h7);
    s.exw = 2'b11; s.exa = 4'h2; s.exl = 1; s.exd = 32'hdead_beef;
    cyc(s);
    s.exw = 2'b00; s.exl = 0;
    cyc(s);

    // stall holds outputs for three cycles, flush during stall kills
    s = idle(); s.valid = 1; s.pc = 32'h10c; s.ir = mk_ir(T_LDI, 4'h0, 4'h9, 4'h0, 4'h0);
    cyc(s);
    s.stall = 1; s.pc = 32'h110; s.ir = mk_ir(T_ALU, 4'h0, 4'h0, 4'h3, 4'h5);
    s.wbw = 2'b11; s.wba = 4'h3; s.wbd = 32'h7777_8888;
    cyc(s); cyc(s); cyc(s);
    s.flush = 1;
    cyc(s);

    // reset mid-stream clears outputs and every register
    s = idle(); s.valid = 1; s.pc = 32'h114; s.ir = mk_ir(T_ALU, 4'h0, 4'h0, 4'h5, 4'h3);
    cyc(s);
    s.rst = 1; s.wbw = 2'b11; s.wba = 4'h5; s.wbd = 32'h5555_5555;
    cyc(s);
    s = idle(); s.valid = 1; s.pc = 32'h118; s.ir = mk_ir(T_ALU, 4'h0, 4'h0, 4'h3, 4'h5);
    cyc(s);

    // write-enable decode and the no-forwarding hazard
    s = idle(); s.valid = 1; s.pc = 32'h11c; s.ir = mk_ir(T_MOV, 4'b0010, 4'h1, 4'h2, 4'h3);
    cyc(s);
    s.pc = 32'h120; s.ir = mk_ir(T_CMP, 4'h0, 4'h1, 4'h2, 4'h3);
    cyc(s);
    s.pc = 32'h124; s.ir = mk_ir(T_ALU, 4'h0, 4'h0, 4'h4, 4'h6);
    s.exw = 2'b11; s.exa = 4'h4; s.exd = 32'h0bad_cafe;
    cyc(s);

    for (int n = 0; n < 600; n++) begin
      s = idle();
      s.rst   = ($urandom_range(0, 99) < 2);
      s.valid = ($urandom_range(0, 99) < 80);
      s.ir    = mk_ir(4'($urandom), 4'($urandom), 4'($urandom_range(0, 5)),
                      4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)));
      s.pc    = $urandom;
      s.stall = ($urandom_range(0, 99) < 15);
      s.flush = ($urandom_range(0, 99) < 8);
      s.wbw   = 2'($urandom);
      s.wba   = 4'($urandom_range(0, 5));
      s.wbd   = $urandom;
      s.exw   = 2'($urandom);
      s.exa   = 4'($urandom_range(0, 5));
      s.exd   = $urandom;
      s.exl   = ($urandom_range(0, 99) < 25);
      cyc(s);
    end

    s = idle();
    cyc(s);
    @(posedge clk);
    #5;
    tests++;
    if (comb_q.size() != 0 || reg_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d/%0d entries left, expected 0/0", comb_q.size(), reg_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
